// File: rtl/synapse_accumulator_pkg.sv
// Shared constants for the synapse accumulator: default sizes, saturation
// limits and FSM state encodings.
`ifndef SYNAPSE_ACCUMULATOR_PKG_SV
`define SYNAPSE_ACCUMULATOR_PKG_SV

`define SAT_MAX(w) {1'b0, {((w)-1){1'b1}}}
`define SAT_MIN(w) {1'b1, {((w)-1){1'b0}}}

package synapse_accumulator_pkg;

  localparam int DEF_V_SIZE   = 4;
  localparam int DEF_N_INPUTS = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

`endif

// File: rtl/synapse_accumulator_sat_add.sv
// Combinational signed saturating adder: clamps to the V_SIZE-bit range
// when the wrapped sum overflows.
import synapse_accumulator_pkg::*;

module sat_add #(
  parameter int V_SIZE = DEF_V_SIZE
) (
  input  logic [V_SIZE-1:0] a,
  input  logic [V_SIZE-1:0] b,
  output logic [V_SIZE-1:0] y
);

  logic [V_SIZE-1:0] sum;

  always_comb begin
    sum = a + b;
    if (!a[V_SIZE-1] && !b[V_SIZE-1] && sum[V_SIZE-1]) begin
      y = `SAT_MAX(V_SIZE);
    end else if (a[V_SIZE-1] && b[V_SIZE-1] && !sum[V_SIZE-1]) begin
      y = `SAT_MIN(V_SIZE);
    end else begin
      y = sum;
    end
  end

endmodule

// File: rtl/synapse_accumulator.sv
// Serial saturating sum of synaptic weights for active spike inputs, emitted
// as a one-cycle current pulse. Define SYN_SKIP_ZERO_EN to visit only set bits.
import synapse_accumulator_pkg::*;

module synapse_accumulator #(
  parameter int N_INPUTS = DEF_N_INPUTS,
  parameter int V_SIZE   = DEF_V_SIZE,
  localparam int IDX_W   = $clog2(N_INPUTS)
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                start,
  input  logic [N_INPUTS-1:0] spikes,
  input  logic                w_we,
  input  logic [IDX_W-1:0]    w_addr,
  input  logic [V_SIZE-1:0]   w_data,
  output logic                busy,
  output logic [V_SIZE-1:0]   current_out,
  output logic                current_valid
);

  logic [1:0]          state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [V_SIZE-1:0]   acc_q, acc_d;
  logic [V_SIZE-1:0]   cur_q, cur_d;
  logic                valid_q, valid_d;
  logic [N_INPUTS-1:0] spikes_q, spikes_d;
  logic [V_SIZE-1:0]   w_q [N_INPUTS];
  logic [V_SIZE-1:0]   w_d [N_INPUTS];
  logic [V_SIZE-1:0]   sum;

  sat_add #(.V_SIZE(V_SIZE)) u_sat_add (
    .a (acc_q),
    .b (w_q[idx_q]),
    .y (sum)
  );

`ifdef SYN_SKIP_ZERO_EN
  // Returns {found, index} of the lowest set bit of v at or above 'from'.
  function automatic logic [IDX_W:0] next_set(input logic [N_INPUTS-1:0] v,
                                               input int unsigned from);
    logic [IDX_W:0] r;
    r = '0;
    for (int unsigned i = 0; i < N_INPUTS; i++) begin
      if (!r[IDX_W] && i >= from && v[i]) begin
        r = {1'b1, IDX_W'(i)};
      end
    end
    return r;
  endfunction

  logic [IDX_W:0] first_hit, next_hit;
  always_comb begin
    first_hit = next_set(spikes, 0);
    next_hit  = next_set(spikes_q, 32'(idx_q) + 32'd1);
  end
`endif

  always_comb begin
    w_d = w_q;
    if (w_we && ({1'b0, w_addr} < (IDX_W+1)'(N_INPUTS))) begin
      w_d[w_addr] = w_data;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    spikes_d = spikes_q;
    cur_d    = '0;
    valid_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          spikes_d = spikes;
          acc_d    = '0;
          idx_d    = '0;
          state_d  = ST_ACCUM;
`ifdef SYN_SKIP_ZERO_EN
          if (first_hit[IDX_W]) begin
            idx_d = first_hit[IDX_W-1:0];
          end else begin
            state_d = ST_DONE;
          end
`endif
        end
      end
      ST_ACCUM: begin
        if (spikes_q[idx_q]) begin
          acc_d = sum;
        end
`ifdef SYN_SKIP_ZERO_EN
        if (next_hit[IDX_W]) begin
          idx_d = next_hit[IDX_W-1:0];
        end else begin
          idx_d   = '0;
          state_d = ST_DONE;
        end
`else
        if (idx_q == IDX_W'(N_INPUTS - 1)) begin
          idx_d   = '0;
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
`endif
      end
      ST_DONE: begin
        cur_d   = acc_q;
        valid_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      acc_q    <= '0;
      cur_q    <= '0;
      valid_q  <= 1'b0;
      spikes_q <= '0;
      for (int unsigned i = 0; i < N_INPUTS; i++) begin
        w_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      cur_q    <= cur_d;
      valid_q  <= valid_d;
      spikes_q <= spikes_d;
      for (int unsigned i = 0; i < N_INPUTS; i++) begin
        w_q[i] <= w_d[i];
      end
    end
  end

  assign busy          = (state_q != ST_IDLE);
  assign current_out   = cur_q;
  assign current_valid = valid_q;

endmodule

// File: tb/tb_synapse_accumulator.sv
// Directed self-checking bench for synapse_accumulator (N_INPUTS=8, V_SIZE=4).
`timescale 1ns/1ps

module tb_synapse_accumulator;

  logic       clk;
  logic       rstn;
  logic       start;
  logic [7:0] spikes;
  logic       w_we;
  logic [2:0] w_addr;
  logic [3:0] w_data;
  logic       busy;
  logic [3:0] current_out;
  logic       current_valid;

  int n_tests = 0;
  int n_fail  = 0;

  synapse_accumulator #(.N_INPUTS(8), .V_SIZE(4)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .start         (start),
    .spikes        (spikes),
    .w_we          (w_we),
    .w_addr        (w_addr),
    .w_data        (w_data),
    .busy          (busy),
    .current_out   (current_out),
    .current_valid (current_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic write_w(input int addr, input int val);
    @(negedge clk);
    w_we   = 1'b1;
    w_addr = 3'(addr);
    w_data = 4'(val);
    @(posedge clk);
    #1 w_we = 1'b0;
  endtask

  // Start a sum, then check latency, busy duration, value and the zero after the pulse.
  task automatic run_sum(input string tag, input logic [7:0] sp,
                         input int exp_val, input int exp_lat);
    int  n;
    int  busy_cnt;
    bit  seen;
    @(negedge clk);
    start  = 1'b1;
    spikes = sp;
    @(posedge clk);
    #1 start = 1'b0;
    busy_cnt = busy ? 1 : 0;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 30) begin
      @(posedge clk);
      #1 n++;
      if (current_valid) seen = 1'b1;
      else if (busy) busy_cnt++;
    end
    check({tag, "_latency"}, seen ? n : -1, exp_lat);
    check({tag, "_busy_cycles"}, busy_cnt, exp_lat);
    check({tag, "_value"}, $signed(current_out), exp_val);
    @(posedge clk);
    #1;
    check({tag, "_valid_drop"}, int'(current_valid), 0);
    check({tag, "_out_zero"}, $signed(current_out), 0);
  endtask

  int lat_full;
  int lat_03;
  int lat_07;
  int lat_00;
  int lat_81;
  int lat_01;

  initial begin
    int pulses;
    int last_val;

    lat_full = 9;
`ifdef SYN_SKIP_ZERO_EN
    lat_03 = 3; lat_07 = 4; lat_00 = 1; lat_81 = 3; lat_01 = 2;
`else
    lat_03 = 9; lat_07 = 9; lat_00 = 9; lat_81 = 9; lat_01 = 9;
`endif

    rstn = 1'b0; start = 1'b0; spikes = '0;
    w_we = 1'b0; w_addr = '0; w_data = '0;
    #22;
    check("reset_busy", int'(busy), 0);
    check("reset_valid", int'(current_valid), 0);
    check("reset_out", $signed(current_out), 0);
    @(negedge clk);
    rstn = 1'b1;

    write_w(0, 3);
    write_w(1, 2);
    run_sum("basic", 8'h03, 5, lat_03);

    write_w(1, 5);
    run_sum("pos_clamp", 8'h03, 7, lat_03);

    write_w(2, -6);
    write_w(3, -5);
    run_sum("neg_clamp", 8'h0C, -8, lat_03);

    write_w(0, 7);
    write_w(1, 1);
    write_w(2, -2);
    run_sum("order_dep", 8'h07, 5, lat_07);

    run_sum("no_spikes", 8'h00, 0, lat_00);

    write_w(7, -3);
    run_sum("ends", 8'h81, 4, lat_81);

    // Second start at edge k+3 while busy must be ignored.
    @(negedge clk);
    start  = 1'b1;
    spikes = 8'h81;
    @(posedge clk);
    #1 start = 1'b0;
    pulses   = 0;
    last_val = 99;
    for (int i = 1; i <= 25; i++) begin
      if (i == 3) begin
        @(negedge clk);
        start  = 1'b1;
        spikes = 8'hFF;
      end
      @(posedge clk);
      #1 start = 1'b0;
      if (current_valid) begin
        pulses++;
        last_val = $signed(current_out);
      end
    end
    check("busy_start_pulses", pulses, 1);
    check("busy_start_value", last_val, 4);

    // Write w0 on the same edge that reads it: the sum uses the old value.
    @(negedge clk);
    start  = 1'b1;
    spikes = 8'h01;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    w_we = 1'b1; w_addr = 3'd0; w_data = 4'd1;
    @(posedge clk);
    #1 w_we = 1'b0;
    pulses   = 0;
    last_val = 99;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (current_valid) begin
        pulses++;
        last_val = $signed(current_out);
      end
    end
    check("wr_collide_pulses", pulses, 1);
    check("wr_collide_old", last_val, 7);
    run_sum("wr_collide_new", 8'h01, 1, lat_01);

    // Asynchronous reset in the middle of a sum.
    @(negedge clk);
    start  = 1'b1;
    spikes = 8'hFF;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #3 rstn = 1'b0;
    #1;
    check("midrst_busy", int'(busy), 0);
    check("midrst_valid", int'(current_valid), 0);
    check("midrst_out", $signed(current_out), 0);
    @(negedge clk);
    rstn = 1'b1;
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      if (current_valid) pulses++;
    end
    check("midrst_no_pulse", pulses, 0);
    run_sum("midrst_w_cleared", 8'hFF, 0, lat_full);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/synapse_accumulator.md
Name: synapse_accumulator

Overview:
Upstream feeder for the leaky integrate-and-fire neuron. Once per timestep it takes an N-bit input spike vector and serially sums the signed synaptic weights of the active inputs with saturation. It presents the result as a one-cycle signed current pulse on the neuron's spike_in bus. Weights live in an internal register array written through a simple write port.

Parameters:
- N_INPUTS, 8, number of presynaptic inputs (≥2).
- V_SIZE, 4, width of weights and output current, signed two's complement; matches the neuron's V_SIZE.
- IDX_W, $clog2(N_INPUTS), index/counter width (derived; do not override).

Ports:
- clk  in  1  rising-edge clock
- rstn  in  1  asynchronous active-low reset
- start  in  1  begin a timestep; sampled only in IDLE
- spikes  in  N_INPUTS  input spike vector, latched on the accepted start edge
- w_we  in  1  weight write enable
- w_addr  in  IDX_W  weight index to write
- w_data  in  V_SIZE  signed weight value
- busy  out  1  high while not IDLE
- current_out  out  V_SIZE  signed summed current; 0 whenever current_valid is low
- current_valid  out  1  one-cycle pulse marking current_out valid

Behaviour:
- Reset (async, rstn=0): state=IDLE, idx=0, acc=0, latched spikes=0, all weights=0, busy=0, current_out=0, current_valid=0. Asserting reset mid-operation aborts the sum; no valid pulse follows.
- FSM states: IDLE, ACCUM, DONE.
- IDLE: start=1 at edge k latches spikes, clears acc and idx, and moves to ACCUM.
- ACCUM: each cycle, if spikes_q[idx]=1 then acc <= sat(acc + w[idx]), else acc holds. idx increments. After processing idx=N_INPUTS-1, move to DONE.
- DONE: current_out <= acc and current_valid <= 1 for exactly one cycle, then return to IDLE.
- Registered outputs: current_valid=1 in the cycle after edge k+N_INPUTS+1. current_out returns to 0 on the following edge.
- start while busy: ignored, with no queuing or error. start may be re-accepted in the first IDLE cycle after DONE. Back-to-back throughput is one sum per N_INPUTS+2 cycles.
- Saturating add: compute the V_SIZE-bit wrapped sum.
  - Both operands non-negative with a negative result: clamp to 2^(V_SIZE-1)-1.
  - Both operands negative with a non-negative result: clamp to -2^(V_SIZE-1).
  - Otherwise use the wrapped sum.
  - Saturation is applied per addition, so the result is order-dependent (ascending index).
- Weight writes are accepted in any state. A write and a read of the same index on the same edge: the read uses the old value and the new value applies from the next cycle. Out-of-range w_addr (≥N_INPUTS) is ignored.
- The downstream neuron should use current_valid as its integration enable. current_out=0 otherwise, so an ungated neuron sees zero input between pulses.

Optional Feature:
- Macro SYN_SKIP_ZERO_EN.
- Defined: ACCUM visits only set bits of spikes_q, jumping idx to the next set bit in ascending order via a priority encoder.
  - For P=popcount(spikes), ACCUM lasts P cycles and current_valid follows edge k+P+1.
  - P=0 goes IDLE→DONE directly; the valid pulse follows edge k+1 with current_out=0.
  - Summation order and saturation results are identical to the non-skip build.
- Undefined: fixed N_INPUTS-cycle scan as above.

Decomposition:
- Shared snn package/header:
  - DEF_V_SIZE and DEF_N_INPUTS.
  - SAT_MAX/SAT_MIN macros derived from V_SIZE.
  - FSM state encodings (IDLE=0, ACCUM=1, DONE=2).
- One natural sub-module: sat_add (pure combinational, signed V_SIZE in ×2, saturated out). Instantiate it once on the acc path.

Test Plan (N_INPUTS=8, V_SIZE=4, skip build off unless stated):
- w0=3, w1=2; start with spikes=8'h03 → after 9 edges, current_valid=1 for 1 cycle with current_out=5; busy=1 for 9 cycles; then current_out=0.
- w0=3, w1=5, spikes=8'h03 → current_out=7 (positive clamp). w2=-6, w3=-5, spikes=8'h0C → current_out=-8 (negative clamp).
- Order dependence: w0=7, w1=1, w2=-2, spikes=8'h07 → 7, then 7 (clamped), then 5 → current_out=5.
- spikes=8'h00 → current_out=0 with valid at edge k+9. With SYN_SKIP_ZERO_EN → valid at edge k+1. With spikes=8'h81 → valid at edge k+3.
- start pulsed again at cycle k+3 while busy → ignored: exactly one valid pulse, value unchanged.
- Reset: rstn low at cycle k+4, asynchronously mid-cycle → busy, current_out and current_valid drop to 0 immediately. No valid pulse follows, and all weights read 0 on the next sum.
